// File: rtl/pu_alu_sched_pkg.sv
// Shared types and constants for the pu_alu_sched ALU scheduler and its datapath.
// Supplies a default for PU_WIDTH_NBITS when the surrounding build does not define it.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif

package pu_alu_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int FUNCT5_ALT = 3;
  localparam int STAT_CNT_W = 32;

  // Index width of a requester id; a single requester still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_alu_sched_if.sv
// Request/result bus between the PU issue stage, the ALU scheduler and writeback.
// The scheduler uses the slave modport; issue/collect logic uses master.
interface pu_alu_sched_if
  import pu_alu_sched_pkg::*;
#(
  parameter int REQ_NUM   = 4,
  parameter int IN_WIDTH  = `PU_WIDTH_NBITS,
  parameter int RF_WIDTH  = 32,
  parameter int OUT_WIDTH = `PU_WIDTH_NBITS,
  parameter int TAG_NBITS = 4,
  parameter int ID_W      = id_width(REQ_NUM)
);

  logic [REQ_NUM-1:0]           req_valid;
  logic [REQ_NUM-1:0]           req_ready;
  logic [REQ_NUM-1:0]           req_use_imm;
  logic [REQ_NUM*IN_WIDTH-1:0]  req_imm;
  logic [REQ_NUM*RF_WIDTH-1:0]  req_rs1;
  logic [REQ_NUM*RF_WIDTH-1:0]  req_rs2;
  logic [REQ_NUM*3-1:0]         req_funct3;
  logic [REQ_NUM*5-1:0]         req_funct5;
  logic [REQ_NUM*TAG_NBITS-1:0] req_tag;

  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_WIDTH-1:0] res_alu;
  logic [ID_W-1:0]      res_id;
  logic [TAG_NBITS-1:0] res_tag;

  modport master (
    output req_valid, req_use_imm, req_imm, req_rs1, req_rs2,
           req_funct3, req_funct5, req_tag, res_ready,
    input  req_ready, res_valid, res_alu, res_id, res_tag
  );

  modport slave (
    input  req_valid, req_use_imm, req_imm, req_rs1, req_rs2,
           req_funct3, req_funct5, req_tag, res_ready,
    output req_ready, res_valid, res_alu, res_id, res_tag
  );

endinterface

// File: rtl/pu_alu.sv
// Combinational PU ALU: add/sub, shifts, compares and bitwise ops selected by funct3,
// with alt selecting subtract or arithmetic right shift.
module pu_alu
  import pu_alu_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  input  logic             alt,
  output logic [WIDTH-1:0] y
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    y = '0;
    case (funct3)
      F3_ADD:  y = alt ? (a - b) : (a + b);
      F3_SLL:  y = a << shamt;
      F3_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      F3_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      F3_XOR:  y = a ^ b;
      F3_SRL: begin
        // Kept as an if so the signed operand is not demoted by a mixed ?: .
        if (alt) y = $signed(a) >>> shamt;
        else     y = a >> shamt;
      end
      F3_OR:   y = a | b;
      F3_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/pu_alu_sched.sv
// Round-robin scheduler sharing one pu_alu among REQ_NUM requesters, with a one-entry
// valid/ready result register. Optional grant counters under PU_ALU_SCHED_STATS_EN.
//
//   state | meaning
//   EMPTY | no result held; any winning request is accepted
//   FULL  | result held on res_*; new request accepted only when res_ready
module pu_alu_sched
  import pu_alu_sched_pkg::*;
#(
  parameter int REQ_NUM   = 4,
  parameter int IN_WIDTH  = `PU_WIDTH_NBITS,
  parameter int RF_WIDTH  = 32,
  parameter int OUT_WIDTH = `PU_WIDTH_NBITS,
  parameter int TAG_NBITS = 4
) (
  input  logic clk,
  input  logic rstn,
  pu_alu_sched_if.slave bus
`ifdef PU_ALU_SCHED_STATS_EN
  ,
  input  logic                            stat_clr,
  output logic [REQ_NUM*STAT_CNT_W-1:0]   stat_gnt_cnt
`endif
);

  localparam int ID_W = id_width(REQ_NUM);

  out_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OUT_WIDTH-1:0] res_alu_q, res_alu_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [TAG_NBITS-1:0] res_tag_q, res_tag_d;

  logic [REQ_NUM-1:0]   gnt;
  logic [REQ_NUM-1:0]   req_ready;
  logic [ID_W-1:0]      winner;
  logic                 found;
  logic                 accept;
  logic                 xfer;
  int                   idx;

  // Scan from rr_ptr upward, wrapping; first valid requester wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < REQ_NUM; off++) begin
      idx = int'(rr_ptr_q) + off;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && bus.req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = ID_W'(idx);
      end
    end
  end

  assign accept        = (state_q == EMPTY) | bus.res_ready;
  assign req_ready     = gnt & {REQ_NUM{accept & rstn}};
  assign xfer          = |(bus.req_valid & req_ready);
  assign bus.req_ready = req_ready;

  logic [IN_WIDTH-1:0]  sel_imm;
  logic [RF_WIDTH-1:0]  sel_rs1;
  logic [RF_WIDTH-1:0]  sel_rs2;
  logic [2:0]           sel_funct3;
  logic [4:0]           sel_funct5;
  logic [TAG_NBITS-1:0] sel_tag;
  logic                 sel_use_imm;

  always_comb begin
    sel_imm     = bus.req_imm[int'(winner)*IN_WIDTH +: IN_WIDTH];
    sel_rs1     = bus.req_rs1[int'(winner)*RF_WIDTH +: RF_WIDTH];
    sel_rs2     = bus.req_rs2[int'(winner)*RF_WIDTH +: RF_WIDTH];
    sel_funct3  = bus.req_funct3[int'(winner)*3 +: 3];
    sel_funct5  = bus.req_funct5[int'(winner)*5 +: 5];
    sel_tag     = bus.req_tag[int'(winner)*TAG_NBITS +: TAG_NBITS];
    sel_use_imm = bus.req_use_imm[winner];
  end

  // Only the alt bit of funct5 has meaning to this ALU.
  logic unused_funct5;
  assign unused_funct5 = ^sel_funct5;

  logic [RF_WIDTH-1:0] imm_ext;
  logic [RF_WIDTH-1:0] alu_b;
  logic [RF_WIDTH-1:0] alu_y;
  logic [OUT_WIDTH-1:0] alu_out;

  // Narrow immediates are sign-extended; wide ones keep their low bits.
  generate
    if (IN_WIDTH >= RF_WIDTH) begin : g_imm_trunc
      assign imm_ext = sel_imm[RF_WIDTH-1:0];
    end else begin : g_imm_sext
      assign imm_ext = {{(RF_WIDTH-IN_WIDTH){sel_imm[IN_WIDTH-1]}}, sel_imm};
    end
    if (OUT_WIDTH <= RF_WIDTH) begin : g_out_trunc
      assign alu_out = alu_y[OUT_WIDTH-1:0];
    end else begin : g_out_zext
      assign alu_out = {{(OUT_WIDTH-RF_WIDTH){1'b0}}, alu_y};
    end
  endgenerate

  assign alu_b = sel_use_imm ? imm_ext : sel_rs2;

  pu_alu #(
    .WIDTH (RF_WIDTH)
  ) u_alu (
    .a      (sel_rs1),
    .b      (alu_b),
    .funct3 (sel_funct3),
    .alt    (sel_funct5[FUNCT5_ALT]),
    .y      (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    res_alu_d = res_alu_q;
    res_id_d  = res_id_q;
    res_tag_d = res_tag_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (bus.res_ready && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      res_alu_d = alu_out;
      res_id_d  = winner;
      res_tag_d = sel_tag;
      rr_ptr_d  = (winner == ID_W'(REQ_NUM-1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      res_alu_q <= '0;
      res_id_q  <= '0;
      res_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      res_alu_q <= res_alu_d;
      res_id_q  <= res_id_d;
      res_tag_q <= res_tag_d;
    end
  end

  assign bus.res_valid = (state_q == FULL);
  assign bus.res_alu   = res_alu_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_tag   = res_tag_q;

`ifdef PU_ALU_SCHED_STATS_EN
  logic [STAT_CNT_W-1:0] cnt_q [REQ_NUM];
  logic [STAT_CNT_W-1:0] cnt_d [REQ_NUM];

  // Clear wins over a same-cycle grant.
  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stat_clr)                              cnt_d[i] = '0;
      else if (bus.req_valid[i] && req_ready[i]) cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!rstn) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    stat_gnt_cnt = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      stat_gnt_cnt[i*STAT_CNT_W +: STAT_CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_pu_alu_sched.sv
// Directed bench for pu_alu_sched (REQ_NUM=4, 32-bit widths); grant counters are
// exercised when PU_ALU_SCHED_STATS_EN is defined.
module tb_pu_alu_sched;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_errors;

  pu_alu_sched_if #(
    .REQ_NUM (4), .IN_WIDTH (32), .RF_WIDTH (32), .OUT_WIDTH (32), .TAG_NBITS (4)
  ) bus ();

`ifdef PU_ALU_SCHED_STATS_EN
  logic         stat_clr;
  logic [127:0] stat_gnt_cnt;
`endif

  pu_alu_sched #(
    .REQ_NUM (4), .IN_WIDTH (32), .RF_WIDTH (32), .OUT_WIDTH (32), .TAG_NBITS (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef PU_ALU_SCHED_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_gnt_cnt (stat_gnt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic ui, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3,
                         input logic [4:0] f5, input logic [3:0] tag);
    bus.req_valid[i]            = v;
    bus.req_use_imm[i]          = ui;
    bus.req_imm[i*32 +: 32]     = imm;
    bus.req_rs1[i*32 +: 32]     = rs1;
    bus.req_rs2[i*32 +: 32]     = rs2;
    bus.req_funct3[i*3 +: 3]    = f3;
    bus.req_funct5[i*5 +: 5]    = f5;
    bus.req_tag[i*4 +: 4]       = tag;
  endtask

  // Single isolated request: checks grant, then the registered result one cycle later.
  task automatic issue_one(input int i, input logic ui, input logic [31:0] imm,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [2:0] f3,
                           input logic [4:0] f5, input logic [3:0] tag,
                           input logic [31:0] exp_alu, input string name);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << i;
    @(posedge clk); #1;
    set_req(i, 1'b1, ui, imm, rs1, rs2, f3, f5, tag);
    @(negedge clk);
    check_eq($sformatf("%s_req_ready", name), bus.req_ready, exp_rdy);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
    @(negedge clk);
    check_eq($sformatf("%s_res_valid", name), bus.res_valid, 1);
    check_eq($sformatf("%s_res_alu", name), bus.res_alu, exp_alu);
    check_eq($sformatf("%s_res_id", name), bus.res_id, i);
    check_eq($sformatf("%s_res_tag", name), bus.res_tag, tag);
  endtask

  logic [2:0]  rr_f3  [4];
  logic [31:0] rr_exp [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rr_f3  = '{3'b000, 3'b100, 3'b110, 3'b111};
    rr_exp = '{32'd13, 32'd8, 32'd15, 32'd1};   // 10+3, 11^3, 12|3, 13&3

    rstn            = 1'b0;
    bus.res_ready   = 1'b0;
    bus.req_valid   = '0;
    bus.req_use_imm = '0;
    bus.req_imm     = '0;
    bus.req_rs1     = '0;
    bus.req_rs2     = '0;
    bus.req_funct3  = '0;
    bus.req_funct5  = '0;
    bus.req_tag     = '0;
`ifdef PU_ALU_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif

    set_req(0, 1'b1, 1'b0, 0, 1, 1, 3'b000, 5'b0, 4'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_res_alu", bus.res_alu, 0);
    check_eq("rst_res_id", bus.res_id, 0);
    check_eq("rst_res_tag", bus.res_tag, 0);
    @(posedge clk); #1;
    rstn          = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;

    issue_one(2, 1'b0, 0, 32'd7, 32'd5, 3'b000, 5'b01000, 4'hA, 32'd2, "basic_sub");
    issue_one(3, 1'b0, 0, 32'd5, 32'd7, 3'b000, 5'b01000, 4'h3, 32'hFFFF_FFFE, "sub_neg");
    issue_one(0, 1'b1, 32'd4, 32'h8000_0000, 32'd9, 3'b101, 5'b01000, 4'h4, 32'hF800_0000, "imm_sra");
    issue_one(0, 1'b1, 32'd4, 32'h8000_0000, 32'd9, 3'b101, 5'b00000, 4'h5, 32'h0800_0000, "imm_srl");
    issue_one(1, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 3'b010, 5'b0, 4'h6, 32'd1, "slt");
    issue_one(2, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 3'b011, 5'b0, 4'h7, 32'd0, "sltu");
    issue_one(3, 1'b0, 0, 32'd1, 32'd31, 3'b001, 5'b0, 4'h8, 32'h8000_0000, "sll");

    // Pointer is now 0: all four valid should rotate 0,1,2,3,0,...
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      set_req(i, 1'b1, 1'b0, 0, 32'(10 + i), 32'd3, rr_f3[i], 5'b0, 4'(8 + i));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq($sformatf("rr_ready_%0d", k), bus.req_ready, 4'b0001 << (k % 4));
      if (k > 0) begin
        check_eq($sformatf("rr_id_%0d", k), bus.res_id, (k - 1) % 4);
        check_eq($sformatf("rr_alu_%0d", k), bus.res_alu, rr_exp[(k - 1) % 4]);
        check_eq($sformatf("rr_valid_%0d", k), bus.res_valid, 1);
      end
      @(posedge clk); #1;
    end

    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1010;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_eq($sformatf("bp_ready_%0d", j), bus.req_ready, 0);
      check_eq($sformatf("bp_id_%0d", j), bus.res_id, 3);
      check_eq($sformatf("bp_alu_%0d", j), bus.res_alu, 1);
      check_eq($sformatf("bp_valid_%0d", j), bus.res_valid, 1);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    check_eq("b2b_id1", bus.res_id, 1);
    check_eq("b2b_alu1", bus.res_alu, 8);
    check_eq("b2b_ready3", bus.req_ready, 4'b1000);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check_eq("b2b_id3", bus.res_id, 3);
    check_eq("b2b_alu3", bus.res_alu, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("drain_valid", bus.res_valid, 0);

    // Leaves pointer at 2 with a result pending, then reset.
    issue_one(1, 1'b0, 0, 32'd1, 32'd1, 3'b000, 5'b0, 4'h5, 32'd2, "pre_rst");
    bus.res_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 0, 32'd20, 32'd1, 3'b000, 5'b0, 4'h6);
    set_req(2, 1'b1, 1'b0, 0, 32'd20, 32'd1, 3'b100, 5'b0, 4'h9);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_res_valid", bus.res_valid, 0);
    check_eq("midrst_res_alu", bus.res_alu, 0);
    check_eq("midrst_res_id", bus.res_id, 0);
    check_eq("midrst_res_tag", bus.res_tag, 0);
    check_eq("midrst_req_ready", bus.req_ready, 0);
    rstn          = 1'b1;
    bus.res_ready = 1'b1;
    #1;
    check_eq("postrst_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    check_eq("postrst_id", bus.res_id, 0);
    check_eq("postrst_alu", bus.res_alu, 21);
    check_eq("postrst_tag", bus.res_tag, 4'h6);

`ifdef PU_ALU_SCHED_STATS_EN
    check_eq("stat_cnt0_pre", stat_gnt_cnt[31:0], 1);
    @(posedge clk); #1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    check_eq("stat_cnt0_clr", stat_gnt_cnt[31:0], 0);
    set_req(1, 1'b1, 1'b0, 0, 32'd2, 32'd2, 3'b000, 5'b0, 4'h2);
    repeat (10) @(posedge clk);
    #1;
    bus.req_valid = '0;
    check_eq("stat_cnt1_10", stat_gnt_cnt[63:32], 10);
    check_eq("stat_cnt0_0", stat_gnt_cnt[31:0], 0);
    bus.req_valid[1] = 1'b1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = '0;
    stat_clr      = 1'b0;
    check_eq("stat_clr_prio", stat_gnt_cnt[63:32], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pu_alu_sched.md
Name: pu_alu_sched

Overview:
- Shares one combinational pu_alu datapath among REQ_NUM requesters (PU execution contexts).
- Each cycle, a round-robin arbiter grants at most one valid request and drives its operands/opcode into the shared ALU.
- The result is captured into a one-entry output register with valid/ready backpressure, tagged with requester id and caller tag.
- Sits between the PU issue stage and the writeback/collect logic.

Parameters:
- REQ_NUM, 4, number of requesters (>=1).
- IN_WIDTH, `PU_WIDTH_NBITS, immediate width.
- RF_WIDTH, 32, register operand width.
- OUT_WIDTH, `PU_WIDTH_NBITS, result width.
- TAG_NBITS, 4, opaque per-request tag width.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- req_valid  in  REQ_NUM  request valid per requester
- req_ready  out  REQ_NUM  request accepted this cycle (one-hot or zero)
- req_use_imm  in  REQ_NUM  select imm for operand b
- req_imm  in  REQ_NUM*IN_WIDTH  immediates, requester i at slice i
- req_rs1  in  REQ_NUM*RF_WIDTH  operand a
- req_rs2  in  REQ_NUM*RF_WIDTH  operand b
- req_funct3  in  REQ_NUM*3  ALU op
- req_funct5  in  REQ_NUM*5  ALU op modifier (bit 3: sub / arithmetic shift)
- req_tag  in  REQ_NUM*TAG_NBITS  caller tag, returned with the result
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_alu  out  OUT_WIDTH  registered ALU result
- res_id  out  $clog2(REQ_NUM) (min 1)  winning requester index
- res_tag  out  TAG_NBITS  tag of that request

Behaviour:
- Output stage FSM, 2 states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
  - accept = (state==EMPTY) | res_ready.
  - EMPTY -> FULL on transfer.
  - FULL -> EMPTY on res_ready with no transfer.
  - FULL -> FULL on res_ready with transfer (back-to-back; registers reloaded), or on !res_ready (registers held).
- Arbitration (combinational):
  - Start index rr_ptr; pick the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod REQ_NUM.
  - gnt is one-hot.
  - req_ready = gnt & {REQ_NUM{accept}}.
  - Transfer on requester i = req_valid[i] & req_ready[i].
- rr_ptr:
  - Updates only on transfer: rr_ptr <= (winner==REQ_NUM-1) ? 0 : winner+1.
  - Otherwise held.
  - For REQ_NUM=1, rr_ptr is constant 0.
- Requester rules:
  - Once req_valid[i] is high, it and its payload stay stable until req_ready[i].
  - req_ready never depends combinationally on the same requester's payload; it depends only on req_valid, rr_ptr and res_ready.
- ALU sourcing and result capture:
  - The ALU is fed from the winner's slice.
  - On transfer, res_alu / res_id / res_tag are loaded with the ALU output, winner index and winner tag.
  - Latency: 1 cycle from transfer to res_valid; throughput 1 result/cycle when res_ready stays high.
- Backpressure: FULL with res_ready=0 gives req_ready=0 for all requesters; the pointer and output registers are frozen.
- No valid requests: no transfer, pointer held.
- Reset (rstn=0 at a clk edge):
  - state=EMPTY, res_valid=0, res_alu=0, res_id=0, res_tag=0, rr_ptr=0.
  - req_ready is forced 0 while rstn=0.
  - A pending result is dropped on reset mid-operation; requesters must re-issue.
- Fairness: with all requesters continuously valid and res_ready=1, grants rotate 0,1,...,REQ_NUM-1,0,...
- ALU semantics (per funct3 / funct5[3]):
  - add/sub, sll, slt, sltu, xor, srl/sra, or, and.
  - The result is truncated to OUT_WIDTH.

Optional Feature:
- PU_ALU_SCHED_STATS_EN defined:
  - Adds output stat_gnt_cnt, REQ_NUM*32 bits: per-requester 32-bit grant counters, incremented on each transfer, wrapping at 2^32.
  - Adds input stat_clr (1 bit): synchronous clear of all counters.
  - stat_clr has priority over a same-cycle increment.
  - Counters reset to 0 on rstn=0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pu_alu_sched_pkg:
  - out-stage state enum {EMPTY, FULL}.
  - ALU funct3 opcode constants (ADD=000 … AND=111).
  - FUNCT5_ALT bit index (3).
  - Stat counter width constant (32).
- One sub-module: instance of the existing pu_alu as the shared datapath.
- The arbiter stays inline. A separate pu_rr_arb is acceptable if reused elsewhere.

Test Plan:
- Basic op: REQ_NUM=4, only req 2 valid with rs1=7, rs2=5, funct3=000, funct5=01000, tag=0xA.
  - Expect res next cycle: res_alu=2, res_id=2, res_tag=0xA.
- Round-robin: all 4 valid for 8 cycles, res_ready=1.
  - Expect res_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
- Backpressure: result pending, res_ready=0 for 3 cycles, reqs 1 and 3 valid.
  - Expect req_ready=0000, res_alu/res_id stable, rr_ptr unchanged.
  - On res_ready=1, req 1 granted in the same cycle (back-to-back).
- Immediate/shift: req 0 with use_imm=1, imm=4, rs1=0x80000000, funct3=101, funct5=01000.
  - Expect res_alu=0xF8000000.
  - Same with funct5=0: expect 0x08000000.
- Reset mid-op: rstn=0 for 1 cycle while res_valid=1.
  - Expect res_valid=0, all res_* outputs 0, req_ready=0.
  - The next grant goes to the lowest-index valid requester (rr_ptr=0).
- Stats (PU_ALU_SCHED_STATS_EN): 10 grants to req 1.
  - Expect its counter=10.
  - stat_clr in the same cycle as a grant gives 0.
